// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one single-ported, word-wide SRAM between the
// instruction fetch port (read-only) and the MEM-stage port (load/store).
// It grants one access at a time and holds the RAM pins for a fixed
// WAIT_CYCLES cycles. It returns read data with a one-cycle ready pulse,
// and it raises stall_req while a request is still waiting.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_req/if_addr           fetch request and byte address
//   if_rdata/if_ready        fetched word and completion pulse
//   mem_req/mem_we/mem_be    data request, store flag, store byte enables
//   mem_addr/mem_wdata       data byte address and store data
//   mem_rdata/mem_ready      load data and completion pulse
//   ram_en/ram_we/ram_be     registered SRAM controls
//   ram_addr/ram_wdata       registered SRAM word address and write data
//   ram_rdata                SRAM read data, valid on the last access cycle
//   stall_req                combinational stall request to the pipeline
module sram_bus_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_W      = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [3:0]        mem_be,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              stall_req
);

  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_ACC  = 2'd1,
    MEM_ACC = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;

  // Byte-offset and high address bits do not reach the word-addressed RAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                              mem_addr[31:ADDR_W+2], mem_addr[1:0]};

  // A request is stalled until its own ready pulse is on the output.
  assign stall_req = (if_req & ~if_ready) | (mem_req & ~mem_ready);

  // Arbitration FSM with registered RAM pins and completion outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_be    <= 4'h0;
      ram_addr  <= '0;
      ram_wdata <= 32'h0;
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      if_rdata  <= 32'h0;
      mem_rdata <= 32'h0;
    end else begin
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          // MEM wins: its access belongs to an older instruction than the fetch.
          if (mem_req) begin
            state_q   <= MEM_ACC;
            ram_en    <= 1'b1;
            ram_we    <= mem_we;
            ram_be    <= mem_we ? mem_be : 4'hF;
            ram_addr  <= mem_addr[ADDR_W+1:2];
            ram_wdata <= mem_we ? mem_wdata : 32'h0;
          end else if (if_req) begin
            state_q   <= IF_ACC;
            ram_en    <= 1'b1;
            ram_we    <= 1'b0;
            ram_be    <= 4'hF;
            ram_addr  <= if_addr[ADDR_W+1:2];
            ram_wdata <= 32'h0;
          end
        end
        IF_ACC, MEM_ACC: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= DONE;
            cnt_q   <= '0;
            ram_en  <= 1'b0;
            ram_we  <= 1'b0;
            ram_be  <= 4'h0;
            if (state_q == IF_ACC) begin
              if_ready <= 1'b1;
              if_rdata <= ram_rdata;
            end else begin
              mem_ready <= 1'b1;
              // A store leaves the previous load data visible.
              if (!ram_we) begin
                mem_rdata <= ram_rdata;
              end
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: instance 0 uses WAIT_CYCLES=2 with a writable
// RAM stub; instance 1 uses WAIT_CYCLES=1 with a read-only RAM stub.
// A transaction-level model schedules each granted access in time.
module tb_sram_bus_arbiter;

  localparam int unsigned AW = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          if_req    [2];
  logic [31:0]   if_addr   [2];
  logic [31:0]   if_rdata  [2];
  logic          if_ready  [2];
  logic          mem_req   [2];
  logic          mem_we    [2];
  logic [3:0]    mem_be    [2];
  logic [31:0]   mem_addr  [2];
  logic [31:0]   mem_wdata [2];
  logic [31:0]   mem_rdata [2];
  logic          mem_ready [2];
  logic          ram_en    [2];
  logic          ram_we    [2];
  logic [3:0]    ram_be    [2];
  logic [AW-1:0] ram_addr  [2];
  logic [31:0]   ram_wdata [2];
  logic [31:0]   ram_rdata [2];
  logic          stall_req [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sram_bus_arbiter #(
      .WAIT_CYCLES((g == 0) ? 2 : 1),
      .ADDR_W     (AW)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req[g]),
      .if_addr   (if_addr[g]),
      .if_rdata  (if_rdata[g]),
      .if_ready  (if_ready[g]),
      .mem_req   (mem_req[g]),
      .mem_we    (mem_we[g]),
      .mem_be    (mem_be[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g]),
      .mem_ready (mem_ready[g]),
      .ram_en    (ram_en[g]),
      .ram_we    (ram_we[g]),
      .ram_be    (ram_be[g]),
      .ram_addr  (ram_addr[g]),
      .ram_wdata (ram_wdata[g]),
      .ram_rdata (ram_rdata[g]),
      .stall_req (stall_req[g])
    );
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int wc(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic logic [31:0] init_word(input logic [AW-1:0] a);
    return 32'hC0DE_0000 ^ {12'h0, a};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // RAM stubs: instance 0 writable, instance 1 returns init_word only.
  logic [31:0] ram0 [int];

  function automatic logic [31:0] stub_read(input logic [AW-1:0] a);
    return ram0.exists(int'(a)) ? ram0[int'(a)] : init_word(a);
  endfunction

  always @(negedge clk) begin
    ram_rdata[0] = stub_read(ram_addr[0]);
    ram_rdata[1] = init_word(ram_addr[1]);
  end

  always @(posedge clk) begin
    if (ram_en[0] === 1'b1 && ram_we[0] === 1'b1)
      ram0[int'(ram_addr[0])] = merge(stub_read(ram_addr[0]), ram_wdata[0], ram_be[0]);
  end

  // Transaction model: a grant at the end of cycle s occupies the RAM during
  // s+1..s+W, completes in s+W+1, and the port is free again from s+W+2.
  logic [31:0]   img [int];
  bit            busy    [2];
  int            st      [2];
  bit            g_mem   [2];
  bit            g_we    [2];
  logic [3:0]    g_be    [2];
  logic [AW-1:0] g_addr  [2];
  logic [31:0]   g_wdata [2];
  logic [31:0]   g_rd    [2];
  logic [31:0]   x_if_rdata  [2];
  logic [31:0]   x_mem_rdata [2];
  bit            model_valid = 1'b0;

  function automatic logic [31:0] model_read(input int i, input logic [AW-1:0] a);
    if (i == 0 && img.exists(int'(a))) return img[int'(a)];
    return init_word(a);
  endfunction

  always @(posedge clk) begin : model_p
    logic [AW-1:0] a;
    logic          w;
    logic [3:0]    b;
    logic [31:0]   d;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        busy[i]        <= 1'b0;
        x_if_rdata[i]  <= 32'h0;
        x_mem_rdata[i] <= 32'h0;
      end else begin
        if (busy[i] && cyc == st[i] + wc(i) && !g_we[i]) begin
          if (g_mem[i]) x_mem_rdata[i] <= g_rd[i];
          else          x_if_rdata[i]  <= g_rd[i];
        end
        if (!busy[i] && (mem_req[i] || if_req[i])) begin
          w = mem_req[i] & mem_we[i];
          a = mem_req[i] ? mem_addr[i][AW+1:2] : if_addr[i][AW+1:2];
          b = w ? mem_be[i] : 4'hF;
          d = w ? mem_wdata[i] : 32'h0;
          busy[i]    <= 1'b1;
          st[i]      <= cyc;
          g_mem[i]   <= mem_req[i];
          g_we[i]    <= w;
          g_addr[i]  <= a;
          g_be[i]    <= b;
          g_wdata[i] <= d;
          g_rd[i]    <= model_read(i, a);
          if (w && i == 0) img[int'(a)] = merge(model_read(0, a), d, b);
        end else if (busy[i] && cyc == st[i] + wc(i) + 1) begin
          busy[i] <= 1'b0;
        end
      end
    end
    if (rst) model_valid <= 1'b1;
    cyc <= cyc + 1;
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      for (int i = 0; i < 2; i++) begin
        bit x_en, x_ifr, x_memr, x_stall;
        x_en    = busy[i] && cyc >= st[i] + 1 && cyc <= st[i] + wc(i);
        x_ifr   = busy[i] && !g_mem[i] && cyc == st[i] + wc(i) + 1;
        x_memr  = busy[i] &&  g_mem[i] && cyc == st[i] + wc(i) + 1;
        x_stall = (if_req[i] & ~x_ifr) | (mem_req[i] & ~x_memr);
        check($sformatf("ram_en[%0d]", i),    32'(ram_en[i]),    32'(x_en));
        check($sformatf("ram_we[%0d]", i),    32'(ram_we[i]),    32'(x_en & g_we[i]));
        if (x_en) begin
          check($sformatf("ram_addr[%0d]", i), 32'(ram_addr[i]), 32'(g_addr[i]));
          check($sformatf("ram_be[%0d]", i),   32'(ram_be[i]),   32'(g_be[i]));
          if (g_we[i]) check($sformatf("ram_wdata[%0d]", i), ram_wdata[i], g_wdata[i]);
        end
        check($sformatf("if_ready[%0d]", i),  32'(if_ready[i]),  32'(x_ifr));
        check($sformatf("mem_ready[%0d]", i), 32'(mem_ready[i]), 32'(x_memr));
        check($sformatf("if_rdata[%0d]", i),  if_rdata[i],       x_if_rdata[i]);
        check($sformatf("mem_rdata[%0d]", i), mem_rdata[i],      x_mem_rdata[i]);
        check($sformatf("stall_req[%0d]", i), 32'(stall_req[i]), 32'(x_stall));
      end
    end
  end

  // Observation counters used by the hand-computed checks.
  int            en_total   [2] = '{0, 0};
  int            we_total   [2] = '{0, 0};
  int            addr_jumps [2] = '{0, 0};
  int            n_if_rdy   [2] = '{0, 0};
  bit            en_prev    [2] = '{0, 0};
  logic [AW-1:0] last_addr  [2];
  logic [3:0]    last_be    [2];
  logic          stall_rdy  [2];
  int            rdy1_q[$];

  always @(negedge clk) begin
    if (model_valid) begin
      for (int i = 0; i < 2; i++) begin
        if (ram_en[i] === 1'b1) begin
          if (en_prev[i] && ram_addr[i] !== last_addr[i]) addr_jumps[i]++;
          en_total[i]++;
          if (ram_we[i] === 1'b1) we_total[i]++;
          last_addr[i] = ram_addr[i];
          last_be[i]   = ram_be[i];
        end
        en_prev[i] = (ram_en[i] === 1'b1);
        if (if_ready[i] === 1'b1) begin
          n_if_rdy[i]++;
          stall_rdy[i] = stall_req[i];
          if (i == 1) rdy1_q.push_back(cyc);
        end
        if (mem_ready[i] === 1'b1) stall_rdy[i] = stall_req[i];
      end
    end
  end

  // Waits (bounded) for a ready pulse; returns at #1 into the cycle after it.
  task automatic wait_ready(input int i, input bit is_mem, output int rc);
    bit got;
    got = 1'b0;
    rc  = -1;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if ((is_mem ? mem_ready[i] : if_ready[i]) === 1'b1) begin
        got = 1'b1;
        rc  = cyc;
      end
    end
    check($sformatf("ready_seen[%0d]", i), 32'(got), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic fetch(input int i, input logic [31:0] a, output int rc);
    if_addr[i] = a;
    if_req[i]  = 1'b1;
    wait_ready(i, 1'b0, rc);
    if_req[i]  = 1'b0;
  endtask

  task automatic memop(input int i, input logic we, input logic [3:0] be,
                       input logic [31:0] a, input logic [31:0] d, output int rc);
    mem_we[i]    = we;
    mem_be[i]    = be;
    mem_addr[i]  = a;
    mem_wdata[i] = d;
    mem_req[i]   = 1'b1;
    wait_ready(i, 1'b1, rc);
    mem_req[i]   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, rc, rc_if, rc_mem, e0, w0, r0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if_req[i] = 1'b0;  if_addr[i] = 32'h0;
      mem_req[i] = 1'b0; mem_we[i] = 1'b0; mem_be[i] = 4'h0;
      mem_addr[i] = 32'h0; mem_wdata[i] = 32'h0;
      ram_rdata[i] = 32'h0;
    end
    ram0[4] = 32'h3421_0001;
    img[4]  = 32'h3421_0001;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ram_en",    32'(ram_en[0]),   32'd0);
    check("rst_ram_addr",  32'(ram_addr[0]), 32'd0);
    check("rst_ram_be",    32'(ram_be[0]),   32'd0);
    check("rst_if_rdata",  if_rdata[0],      32'h0);
    check("rst_mem_rdata", mem_rdata[0],     32'h0);
    check("rst_if_ready",  32'(if_ready[0]), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Fetch from 0x10 -> word 4.
    c0 = cyc; e0 = en_total[0];
    fetch(0, 32'h0000_0010, rc);
    check("fetch_latency", 32'(rc - c0),       32'd3);
    check("fetch_rdata",   if_rdata[0],        32'h3421_0001);
    check("fetch_addr",    32'(last_addr[0]),  32'h4);
    check("fetch_en_cyc",  32'(en_total[0] - e0), 32'd2);
    check("fetch_stall",   32'(stall_rdy[0]),  32'd0);

    // Partial store to 0x104 -> word 0x41.
    c0 = cyc; e0 = en_total[0]; w0 = we_total[0];
    memop(0, 1'b1, 4'b0011, 32'h0000_0104, 32'hDEAD_BEEF, rc);
    check("store_latency", 32'(rc - c0),          32'd3);
    check("store_addr",    32'(last_addr[0]),     32'h41);
    check("store_be",      32'(last_be[0]),       32'h3);
    check("store_we_cyc",  32'(we_total[0] - w0), 32'd2);
    check("store_en_cyc",  32'(en_total[0] - e0), 32'd2);
    check("store_rdata",   mem_rdata[0],          32'h0);

    // Load it back: upper bytes from the initial word, lower from the store.
    memop(0, 1'b0, 4'b0101, 32'h0000_0104, 32'h0, rc);
    check("load_back", mem_rdata[0], 32'hC0DE_BEEF);

    // Simultaneous fetch and load: MEM first, fetch after.
    c0 = cyc;
    fork
      fetch(0, 32'h0000_0010, rc_if);
      memop(0, 1'b0, 4'h0, 32'h0000_0104, 32'h0, rc_mem);
    join
    check("both_mem_lat", 32'(rc_mem - c0), 32'd3);
    check("both_if_lat",  32'(rc_if - c0),  32'd7);

    // Address changes mid-access must not reach the RAM pins.
    e0 = addr_jumps[0];
    fork
      memop(0, 1'b0, 4'h0, 32'h0000_0100, 32'h0, rc);
      begin
        @(posedge clk); #1;
        mem_addr[0] = 32'h0000_0200;
      end
    join
    check("hold_addr",   32'(last_addr[0]),        32'h40);
    check("hold_jumps",  32'(addr_jumps[0] - e0),  32'd0);
    check("hold_rdata",  mem_rdata[0],             32'hC0DE_0040);

    // Reset in the second access cycle of a fetch.
    r0 = n_if_rdy[0];
    if_addr[0] = 32'h0000_0010; if_req[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_en_before", 32'(ram_en[0]), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; if_req[0] = 1'b0;
    check("abort_en",     32'(ram_en[0]),   32'd0);
    check("abort_ready",  32'(if_ready[0]), 32'd0);
    check("abort_rdata",  if_rdata[0],      32'h0);
    repeat (4) @(posedge clk); #1;
    check("abort_no_rdy", 32'(n_if_rdy[0] - r0), 32'd0);
    c0 = cyc;
    fetch(0, 32'h0000_0010, rc);
    check("after_abort_lat",   32'(rc - c0), 32'd3);
    check("after_abort_rdata", if_rdata[0],  32'h3421_0001);

    // WAIT_CYCLES=1, fetch held continuously: ready every 3 cycles.
    rdy1_q.delete();
    c0 = cyc;
    if_addr[1] = 32'h0000_0020; if_req[1] = 1'b1;
    for (int k = 0; k < 3; k++) wait_ready(1, 1'b0, rc);
    if_req[1] = 1'b0;
    check("w1_count", 32'(rdy1_q.size()), 32'd3);
    if (rdy1_q.size() == 3) begin
      check("w1_first",   32'(rdy1_q[0] - c0),        32'd2);
      check("w1_space0",  32'(rdy1_q[1] - rdy1_q[0]), 32'd3);
      check("w1_space1",  32'(rdy1_q[2] - rdy1_q[1]), 32'd3);
    end
    check("w1_rdata", if_rdata[1], 32'hC0DE_0008);

    repeat (4) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares one single-ported, word-wide SRAM between two requesters: instruction fetch (read-only) and the MEM stage (load/store).
- Sits between the pipeline stages and the external RAM pins.
- Grants one access at a time, sequences the fixed-latency SRAM access, and returns data with a one-cycle ready pulse.
- Raises a stall request to the pipeline controller while either requester is waiting.

Parameters:
- WAIT_CYCLES, 2, cycles the RAM control signals are held per access; legal values are 1 and above.
- ADDR_W, 20, SRAM word-address width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- if_req  in  1  fetch request; held high until if_ready.
- if_addr  in  32  fetch byte address.
- if_rdata  out  32  fetched instruction; valid when if_ready is high.
- if_ready  out  1  one-cycle completion pulse for the fetch.
- mem_req  in  1  data request; held high until mem_ready.
- mem_we  in  1  1 = store, 0 = load.
- mem_be  in  4  byte enables for stores; bit i selects byte i.
- mem_addr  in  32  data byte address.
- mem_wdata  in  32  store data.
- mem_rdata  out  32  load data; valid when mem_ready is high.
- mem_ready  out  1  one-cycle completion pulse for the data access.
- ram_en  out  1  RAM access enable.
- ram_we  out  1  RAM write enable.
- ram_be  out  4  RAM byte enables.
- ram_addr  out  ADDR_W  RAM word address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data; valid on the last access cycle.
- stall_req  out  1  to the pipeline controller: some request is pending and not completing this cycle.

Behaviour:
- State machine: IDLE, IF_ACC, MEM_ACC, DONE. A wait counter counts 0..WAIT_CYCLES-1.
- Reset: state = IDLE, counter = 0.
  - ram_en, ram_we, if_ready, mem_ready = 0.
  - ram_be = 0, ram_addr = 0, ram_wdata = 0.
  - if_rdata = 0, mem_rdata = 0.
- IDLE:
  - mem_req has priority over if_req. The data access belongs to an older instruction, so fetch must wait for it.
  - Selected request is latched at edge E0.
  - Next state is MEM_ACC or IF_ACC; counter = 0.
  - With no request, stay in IDLE.
- Registered RAM outputs are driven during IF_ACC and MEM_ACC only:
  - ram_en = 1.
  - ram_addr = addr[ADDR_W+1:2]; addr[1:0] is ignored.
  - Fetch: ram_we = 0, ram_be = 4'b1111.
  - Load: ram_we = 0, ram_be = 4'b1111.
  - Store: ram_we = 1, ram_be = mem_be, ram_wdata = mem_wdata.
  - Address, be and wdata are held constant for the whole access, even if requester inputs change.
- Access timing:
  - Access lasts exactly WAIT_CYCLES cycles: E0+1 through E0+WAIT_CYCLES.
  - On the edge ending the last access cycle:
    - Reads: ram_rdata is captured into if_rdata or mem_rdata.
    - Stores: mem_rdata is unchanged.
    - State moves to DONE; ram_en and ram_we drop to 0.
- DONE:
  - Exactly one of if_ready / mem_ready is high for this single cycle, matching the granted requester.
  - New requests are ignored in DONE.
  - Next state is always IDLE.
- Latency and throughput:
  - Request accepted in IDLE gives ready in cycle E0+WAIT_CYCLES+1.
  - Minimum spacing between accepted requests is WAIT_CYCLES+2 cycles.
- Requester contract: the requester deasserts or replaces its request in the cycle after ready. A held request is served again.
- Simultaneous if_req and mem_req in IDLE: MEM is served first. IF is granted on the first IDLE after MEM's DONE, if still requested and no new mem_req is present.
- stall_req, combinational: (if_req & ~if_ready) | (mem_req & ~mem_ready). It is 0 in the DONE cycle for the requester being completed.
- Read data outputs hold their value until the next read for the same requester.
- Reset mid-access:
  - Synchronous abort; state returns to IDLE on that edge.
  - ram_en = 0 from the next cycle.
  - No ready pulse is issued for the aborted access.
  - Read data registers are cleared to 0.

Test Plan:
- Fetch only, WAIT_CYCLES=2, if_req with if_addr=0x0000_0010, RAM returns 0x3421_0001 -> ram_addr=4 and ram_en high for 2 cycles; if_ready pulses at E0+3 with if_rdata=0x3421_0001; stall_req low in that cycle.
- Store, mem_addr=0x0000_0104, mem_be=4'b0011, mem_wdata=0xDEAD_BEEF -> ram_addr=0x41, ram_we=1, ram_be=0011 for 2 cycles; mem_ready pulses once; mem_rdata unchanged.
- if_req and mem_req (load) asserted in the same IDLE cycle -> MEM_ACC first, mem_ready at E0+3; IF access starts at E0+5, if_ready at E0+7; stall_req high from E0 through the cycle before each ready.
- Requester changes mem_addr from 0x100 to 0x200 during an active access -> ram_addr stays 0x40 for the whole access.
- rst asserted in the second cycle of a fetch -> ram_en=0 the next cycle, no if_ready, if_rdata=0; a following request completes normally.
- WAIT_CYCLES=1 with back-to-back fetches held continuously -> ready every 3 cycles.
